// File: rtl/mul_top.sv
`default_nettype none
// ============================================================================
//  Module      : mul_top
//  Description : Two-stage pipelined signed multiplier. Operands are
//                registered, multiplied by a radix-4 Booth core (partial
//                products reduced with carry-save adders, then one
//                carry-propagate add), and the full-width product is
//                registered on the next edge. One product per clock,
//                latency of two clocks.
//  Ports       : clk    - clock, rising edge active
//                rst_n  - asynchronous active-low reset
//                a      - WIDTH-bit signed multiplicand
//                b      - WIDTH-bit signed multiplier
//                out    - 2*WIDTH-bit registered signed product
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_top #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out
);

  localparam int PW  = 2 * WIDTH;        // product width
  localparam int NPP = (WIDTH + 1) / 2;  // number of Booth partial products
  localparam int BW  = 2 * NPP;          // multiplier width rounded up to even

  // --------------------------------------------------------------------------
  // Stage 1: operand registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [PW-1:0]    out_d, out_q;

  always_comb begin
    a_d = a;
    b_d = b;
  end

  // --------------------------------------------------------------------------
  // Booth recoding
  // --------------------------------------------------------------------------
  logic [BW-1:0] b_sx;    // multiplier sign-extended to an even width
  logic [BW:0]   b_ext;   // with the implicit zero below the LSB
  logic [PW-1:0] a_sx;    // multiplicand sign-extended to product width
  logic [PW-1:0] a2_sx;   // 2a, formed at full width so a = most-negative
                          // value does not lose its sign bit

  assign b_sx  = BW'(signed'(b_q));
  assign b_ext = {b_sx, 1'b0};
  assign a_sx  = PW'(signed'(a_q));
  assign a2_sx = a_sx << 1;

  logic [PW-1:0] pp [NPP];

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [2:0]    trip;
    logic [PW-1:0] sel;

    // Overlapping triplet {b[2i+1], b[2i], b[2i-1]}
    assign trip = b_ext[2*i+2 -: 3];

    always_comb begin
      sel = '0;
      case (trip)
        3'b001, 3'b010: sel = a_sx;
        3'b011:         sel = a2_sx;
        3'b100:         sel = -a2_sx;
        3'b101, 3'b110: sel = -a_sx;
        default:        sel = '0;
      endcase
    end

    // Weight of group i is 4^i; bits shifted past the product width are
    // discarded, which is exact for a modulo-2^PW result.
    assign pp[i] = sel << (2 * i);
  end

  // --------------------------------------------------------------------------
  // Carry-save reduction followed by a single carry-propagate add
  // --------------------------------------------------------------------------
  logic [PW-1:0] cs_sum, cs_carry;

  always_comb begin
    logic [PW-1:0] t_s;
    logic [PW-1:0] t_c;
    t_s      = '0;
    t_c      = '0;
    cs_sum   = pp[0];
    cs_carry = '0;
    for (int i = 1; i < NPP; i++) begin
      t_s      = cs_sum ^ cs_carry ^ pp[i];
      t_c      = ((cs_sum & cs_carry) | (cs_sum & pp[i]) | (cs_carry & pp[i])) << 1;
      cs_sum   = t_s;
      cs_carry = t_c;
    end
    out_d = cs_sum + cs_carry;
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_top
//  Description : Self-checking bench for mul_top. A reference model records
//                the signed product of the operands present at each rising
//                edge; the expected output is the product recorded one edge
//                before the most recent one (zero if fewer than two edges
//                since reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_top;

  localparam int W = 6;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2*W-1:0] out;

  int checks = 0;
  int errors = 0;

  mul_top #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = $signed(x) * $signed(y);
    return (2*W)'(p);
  endfunction

  logic [2*W-1:0] hist [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
    end else begin
      hist.push_back(prod(a, b));
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  function automatic logic [2*W-1:0] model_out();
    if (!rst_n || hist.size() < 2) return '0;
    return hist[hist.size()-2];
  endfunction

  // --------------------------------------------------------------------------
  // Checker
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (a=%h b=%h t=%0t)", tag, obs, exp, a, b, $time);
    end
  endtask

  // Drive operands at a falling edge, then hold for n cycles checking the
  // model at every falling edge; finally compare against a fixed constant.
  task automatic hold(input logic [W-1:0] x, input logic [W-1:0] y, input int n,
                      input string tag, input logic [2*W-1:0] exp_const);
    a = x;
    b = y;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, "_model"}, out, model_out());
    end
    check(tag, out, exp_const);
  endtask

  logic [W-1:0]   tp_a [3];
  logic [W-1:0]   tp_b [3];
  logic [2*W-1:0] tp_e [3];

  initial begin
    // ---------------- reset with operands present ----------------
    rst_n = 1'b1;
    a = 6'd5;
    b = 6'd7;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", out, 12'h000);
    repeat (3) begin
      @(negedge clk);
      check("reset_held", out, 12'h000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("release_edge1", out, 12'h000);
    @(negedge clk);
    check("release_edge2", out, 12'h023);

    // ---------------- basic and sign cases ----------------
    hold(6'd3,  6'd5,  10, "pos_pos",   12'h00F);
    hold(6'h3F, 6'd1,  10, "neg_pos",   12'hFFF);
    hold(6'h3F, 6'h3F, 10, "neg_neg",   12'h001);

    // ---------------- extremes ----------------
    hold(6'h20, 6'h20, 10, "min_min",   12'h400);
    hold(6'h20, 6'd31, 10, "min_max",   12'hC20);
    hold(6'd31, 6'd31, 10, "max_max",   12'h3C1);
    hold(6'd0,  6'h20, 10, "zero_min",  12'h000);

    // ---------------- back-to-back throughput ----------------
    tp_a[0] = 6'd2;  tp_b[0] = 6'd3;  tp_e[0] = 12'h006;
    tp_a[1] = 6'h3C; tp_b[1] = 6'd6;  tp_e[1] = 12'hFE8;
    tp_a[2] = 6'd7;  tp_b[2] = 6'h38; tp_e[2] = 12'hFC8;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        a = tp_a[k];
        b = tp_b[k];
      end else begin
        a = 6'd0;
        b = 6'd0;
      end
      @(negedge clk);
      check("stream_model", out, model_out());
      if (k >= 1 && k <= 3) check("stream_const", out, tp_e[k-1]);
    end

    // ---------------- random back-to-back with mid-stream reset ----------------
    for (int k = 0; k < 400; k++) begin
      a = 6'($urandom);
      b = 6'($urandom);
      if (k == 200) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", out, 12'h000);
        @(negedge clk);
        check("midreset_held", out, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_edge1", out, 12'h000);
        check("midreset_model", out, model_out());
      end else begin
        @(negedge clk);
        check("random", out, model_out());
      end
    end

    // ---------------- exhaustive, each pair held 100 ns ----------------
    for (int i = -32; i < 32; i++) begin
      for (int j = -32; j < 32; j++) begin
        a = 6'(i);
        b = 6'(j);
        repeat (10) @(negedge clk);
        check("exhaustive", out, prod(a, b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_top.md
# mul_top

Pipelined signed multiplier: takes two 6-bit two's-complement operands and produces their full 12-bit two's-complement product. It is the top of the multiplier unit and sits between operand-producing logic and any consumer of the full-width product. Throughput is one product per clock. Latency is two clock cycles.

## Interface
Parameters:
- `WIDTH`, default 6: operand width in bits. The product is `2*WIDTH` bits.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `a`, input, `WIDTH`: multiplicand, signed two's complement, range −32..31.
- `b`, input, `WIDTH`: multiplier, signed two's complement, range −32..31.
- `out`, output, `2*WIDTH`: registered signed product, two's complement.

## Operation
- Stage 1: `a` and `b` are captured into operand registers on every rising `clk`. There is no enable.
- Combinational core:
  - Radix-4 Booth recoding of the registered `b`, sign-extended to an even width.
  - Generates `ceil(WIDTH/2)` partial products of the registered `a`. Each partial product is one of 0, ±a, or ±2a.
  - Partial products are sign-extended to `2*WIDTH` bits.
  - They are summed in a carry-save adder tree, then a final carry-propagate adder.
- Stage 2: the `2*WIDTH`-bit sum is captured into the `out` register on the rising `clk`.
- Arithmetic rule: `out == (a*b) mod 2^(2*WIDTH)`, with `a` and `b` interpreted as signed.
  - For `WIDTH=6` every product fits exactly, with no overflow.
  - Extremes are −32×−32 = +1024 (0x400) and −32×31 = −992 (0xC20).
- The most-negative operand (−32, 100000b) must be handled correctly. Booth −2a on a = −32 needs `WIDTH+1` bits internally, so no truncation is allowed before extension.
- There is no handshake and no valid signal. `out` continuously reflects the operands presented two edges earlier.

## Timing
- Reset value: operand registers = 0 and `out` = 0. Reset takes effect immediately on `rst_n` falling, independent of `clk`.
- Latency: operands stable before rising edge N produce their product on `out` after rising edge N+1. `out` must be valid no later than 2 clock periods after the operands change.
  - Reference clock is 10 ns. Operands held for 100 ns must show the correct product well before the end of the hold.
- Back-to-back: new operands on every cycle give a new product every cycle, each delayed by 2.
- Reset mid-operation: all in-flight results are discarded and `out` forces to 0.
  - After `rst_n` rises, `out` stays 0 until the second rising edge. From then on it shows products of the operands sampled after release.
- Operands held constant: `out` is stable, with no glitching at the register output.
- The combinational core must close timing within one clock period.

## Test plan
- Reset: assert `rst_n`=0 with a=5, b=7 -> `out`=0x000 immediately and while held. Release -> `out`=0x023 (35) after 2 edges.
- Basic and sign cases, each held 10 cycles:
  - a=3, b=5 -> 0x00F.
  - a=−1 (0x3F), b=1 -> 0xFFF.
  - a=−1, b=−1 -> 0x001.
- Extremes:
  - a=−32, b=−32 -> 0x400.
  - a=−32, b=31 -> 0xC20.
  - a=31, b=31 -> 0x3C1 (961).
  - a=0, b=−32 -> 0x000.
- Pipeline throughput: change operands every cycle through (2,3), (−4,6), (7,−8) -> `out` = 0x006, 0xFE8, 0xFC8 on consecutive cycles, starting 2 edges after the first.
- Mid-stream reset: pulse `rst_n` low between clock edges during a stream -> `out` = 0 at once, and the pipeline restarts with 2-cycle latency.
- Exhaustive check:
  - Stimulus: all 4096 (a, b) pairs for a, b in −32..31, each held 100 ns.
  - Response: `out` == (a*b) & 0xFFF at the end of each hold.
  - Pass criterion: zero mismatches.
